// File: rtl/bias_stream_gen_if.sv
// rtl/bias_stream_gen_if.sv - frame handshake and FIFO-write stream bundle for bias_stream_gen
interface bias_stream_gen_if #(
  parameter int OUT_WIDTH = 32
);
  logic                 ap_start;
  logic                 ap_done;
  logic                 ap_idle;
  logic [OUT_WIDTH-1:0] output_V_din;
  logic                 output_V_full_n;
  logic                 output_V_write;

  // master: frame controller / downstream FIFO side
  modport master (
    output ap_start,
    output output_V_full_n,
    input  ap_done,
    input  ap_idle,
    input  output_V_din,
    input  output_V_write
  );

  // slave: the bias streamer itself
  modport slave (
    input  ap_start,
    input  output_V_full_n,
    output ap_done,
    output ap_idle,
    output output_V_din,
    output output_V_write
  );
endinterface

// File: rtl/bias_stream_gen.sv
// rtl/bias_stream_gen.sv - streams NUM_KERN ROM biases REPEAT times per frame; optional BIAS_SHIFT_EN
// ROM contents come from ROM_INIT (entry k at bits [k*COEFF_WIDTH +: COEFF_WIDTH]).
module bias_stream_gen #(
  parameter int                              NUM_KERN    = 16,
  parameter int                              COEFF_WIDTH = 16,
  parameter int                              OUT_WIDTH   = 32,
  parameter int                              REPEAT      = 1,
  parameter int                              BIAS_SHIFT  = 8,
  parameter logic [NUM_KERN*COEFF_WIDTH-1:0] ROM_INIT    = '0
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  bias_stream_gen_if.slave   io
);

  localparam int KW = (NUM_KERN > 1) ? $clog2(NUM_KERN) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_KERN - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT - 1);

`ifdef BIAS_SHIFT_EN
  localparam int SHIFT_ON = 1;
`else
  localparam int SHIFT_ON = 0;
`endif
  localparam int SHIFT_AMT = BIAS_SHIFT * SHIFT_ON;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [KW-1:0]                 k;
  logic [RW-1:0]                 r;
  logic                          rd_issue;
  logic                          rd_vld;
  logic                          last_rd;
  logic signed [COEFF_WIDTH-1:0] rom_q;
  logic signed [OUT_WIDTH-1:0]   word_ext;
  logic [OUT_WIDTH-1:0]          word;
  logic [OUT_WIDTH-1:0]          buf0;
  logic [OUT_WIDTH-1:0]          buf1;
  logic [1:0]                    occ;
  logic                          push;
  logic                          pop;
  logic [2:0]                    committed;

  assign push = rd_vld;
  assign pop  = (occ != 2'd0) && io.output_V_full_n;

  // Entries that will sit in the buffer next cycle; counting the current pop keeps 1 word/cycle.
  assign committed = 3'(occ) - 3'(pop) + 3'(rd_vld);
  assign rd_issue  = (state == S_RUN) && (committed < 3'd2);
  assign last_rd   = (k == K_LAST) && (r == R_LAST);

  assign word_ext = OUT_WIDTH'(rom_q);
  assign word     = word_ext << SHIFT_AMT;

  assign io.output_V_write = pop;
  assign io.output_V_din   = buf0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    io.ap_idle = 1'b0;
    io.ap_done = 1'b0;
    case (state)
      S_IDLE: begin
        io.ap_idle = 1'b1;
        if (io.ap_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (rd_issue && last_rd) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave once the final word is popping this cycle with nothing still in flight.
        if (!rd_vld && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_nxt = S_DONE;
      end
      S_DONE: begin
        io.ap_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      k <= '0;
      r <= '0;
    end else if (state == S_IDLE) begin
      k <= '0;
      r <= '0;
    end else if (rd_issue) begin
      if (k == K_LAST) begin
        k <= '0;
        r <= (r == R_LAST) ? '0 : r + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rom_q  <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_issue) rom_q <= ROM_INIT[k*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end

  // Two-entry buffer with buf0 as head; buf0 only changes on a push into an empty slot or a pop.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      occ  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= word;
          else buf1 <= word;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) buf0 <= buf1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= word;
          end else begin
            buf0 <= buf1;
            buf1 <= word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
